// File: rtl/aucohl_uart_pkg.sv
// Shared types and constants for the aucohl UART receiver.
// Frame layout: start bit, 8 data bits LSB first, optional parity bit, stop bit.
package aucohl_uart_pkg;

  localparam int OVERSAMPLE_DEF = 16;
  localparam int DATA_W         = 8;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } state_e;

  // Even parity holds when data plus parity bit has an even number of ones.
  function automatic logic parity_mismatch(input logic [DATA_W-1:0] data,
                                           input logic              par_bit,
                                           input logic              odd);
    return (^data) ^ par_bit ^ odd;
  endfunction

endpackage

// File: rtl/aucohl_baud_tick.sv
// Oversample tick generator: down-counter that reloads clk_div at zero.
// The tick is high while the count is zero, so clk_div = 0 ticks every cycle.
module aucohl_baud_tick #(
  parameter int DIV_W = 16
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_en,
  input  logic [DIV_W-1:0] i_clk_div,
  output logic             o_tick
);

  logic [DIV_W-1:0] r_cnt;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt <= '0;
    end else if (!i_en) begin
      r_cnt <= '0;
    end else if (r_cnt == '0) begin
      r_cnt <= i_clk_div;
    end else begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_tick = i_en && (r_cnt == '0);

endmodule

// File: rtl/aucohl_uart_rx.sv
// UART receiver: 16x oversampled, mid-bit sampled, pushes good bytes into a FIFO.
// Errors are reported as one-cycle pulses; exactly one outcome per completed frame.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// ST_IDLE   | line idle, waiting for a tick that sees rx low
// ST_START  | counting to mid-start; rx high there is a false start
// ST_DATA   | sampling 8 data bits at each bit centre, LSB first
// ST_PARITY | sampling the parity bit and latching the mismatch flag
// ST_STOP   | at mid-stop: frame error, parity error, overrun or write
module aucohl_uart_rx
  import aucohl_uart_pkg::*;
#(
  parameter int DIV_W      = 16,
  parameter int OVERSAMPLE = OVERSAMPLE_DEF
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_en,
  input  logic [DIV_W-1:0]  i_clk_div,
  input  logic              i_rx,
  input  logic              i_parity_en,
  input  logic              i_parity_odd,
  input  logic              i_fifo_full,
  output logic              o_wr,
  output logic [DATA_W-1:0] o_wdata,
  output logic              o_frame_err,
  output logic              o_parity_err,
  output logic              o_overrun_err
);

  localparam int S_W = $clog2(OVERSAMPLE);
  localparam int B_W = $clog2(DATA_W);
  localparam logic [S_W-1:0] S_LAST = S_W'(OVERSAMPLE - 1);
  localparam logic [S_W-1:0] S_MID  = S_W'(OVERSAMPLE / 2 - 1);
  localparam logic [B_W-1:0] B_LAST = B_W'(DATA_W - 1);

  logic              w_tick;
  state_e            r_state;
  logic [S_W-1:0]    r_s;
  logic [B_W-1:0]    r_b;
  logic [DATA_W-1:0] r_shreg;
  logic              r_par_en;
  logic              r_par_odd;
  logic              r_perr;
  logic              r_wr;
  logic [DATA_W-1:0] r_wdata;
  logic              r_frame_err;
  logic              r_parity_err;
  logic              r_overrun_err;

  aucohl_baud_tick #(
    .DIV_W (DIV_W)
  ) u_baud_tick (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_en      (i_en),
    .i_clk_div (i_clk_div),
    .o_tick    (w_tick)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state       <= ST_IDLE;
      r_s           <= '0;
      r_b           <= '0;
      r_shreg       <= '0;
      r_par_en      <= 1'b0;
      r_par_odd     <= 1'b0;
      r_perr        <= 1'b0;
      r_wr          <= 1'b0;
      r_wdata       <= '0;
      r_frame_err   <= 1'b0;
      r_parity_err  <= 1'b0;
      r_overrun_err <= 1'b0;
    end else begin
      r_wr          <= 1'b0;
      r_frame_err   <= 1'b0;
      r_parity_err  <= 1'b0;
      r_overrun_err <= 1'b0;

      if (!i_en) begin
        r_state <= ST_IDLE;
        r_s     <= '0;
        r_b     <= '0;
      end else if (w_tick) begin
        case (r_state)
          ST_IDLE: begin
            if (!i_rx) begin
              r_state <= ST_START;
              r_s     <= '0;
            end
          end

          ST_START: begin
            if (r_s == S_MID) begin
              r_s <= '0;
              if (i_rx) begin
                r_state <= ST_IDLE;
              end else begin
                r_state   <= ST_DATA;
                r_b       <= '0;
                r_par_en  <= i_parity_en;
                r_par_odd <= i_parity_odd;
                r_perr    <= 1'b0;
              end
            end else begin
              r_s <= r_s + 1'b1;
            end
          end

          ST_DATA: begin
            if (r_s == S_LAST) begin
              r_s          <= '0;
              r_shreg[r_b] <= i_rx;
              if (r_b == B_LAST) begin
                r_b     <= '0;
                r_state <= r_par_en ? ST_PARITY : ST_STOP;
              end else begin
                r_b <= r_b + 1'b1;
              end
            end else begin
              r_s <= r_s + 1'b1;
            end
          end

          ST_PARITY: begin
            if (r_s == S_LAST) begin
              r_s     <= '0;
              r_perr  <= parity_mismatch(r_shreg, i_rx, r_par_odd);
              r_state <= ST_STOP;
            end else begin
              r_s <= r_s + 1'b1;
            end
          end

          ST_STOP: begin
            // Leave at mid-stop so a start bit right after the stop is caught.
            if (r_s == S_LAST) begin
              r_s     <= '0;
              r_state <= ST_IDLE;
              if (!i_rx) begin
                r_frame_err <= 1'b1;
              end else if (r_perr) begin
                r_parity_err <= 1'b1;
              end else if (i_fifo_full) begin
                r_overrun_err <= 1'b1;
              end else begin
                r_wr    <= 1'b1;
                r_wdata <= r_shreg;
              end
            end else begin
              r_s <= r_s + 1'b1;
            end
          end

          default: begin
            r_state <= ST_IDLE;
            r_s     <= '0;
            r_b     <= '0;
          end
        endcase
      end
    end
  end

  assign o_wr          = r_wr;
  assign o_wdata       = r_wdata;
  assign o_frame_err   = r_frame_err;
  assign o_parity_err  = r_parity_err;
  assign o_overrun_err = r_overrun_err;

endmodule

// File: doc/aucohl_uart_rx.md
Name: aucohl_uart_rx

Overview:
- UART receiver that converts a serial line into bytes and pushes them into a downstream aucohl_fifo write port (wr/wdata/full).
- Upstream of the FIFO. The rx input comes from aucohl_sync, optionally followed by aucohl_glitch_filter, so rx is already synchronous to clk.
- Uses a 16x oversampling baud tick, mid-bit sampling, optional parity, and per-frame error pulses.

Parameters:
- DIV_W, 16, width of clk_div.
- OVERSAMPLE, 16, ticks per bit; must be a power of 2, minimum 8.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- en  in  1  receiver enable; low forces IDLE.
- clk_div  in  DIV_W  oversample tick period minus 1; 0 = tick every cycle.
- rx  in  1  serial data, already synchronised, idle high.
- parity_en  in  1  expect parity bit after data.
- parity_odd  in  1  1 = odd parity, 0 = even parity.
- fifo_full  in  1  full flag from the downstream FIFO.
- wr  out  1  one-cycle write strobe to the FIFO.
- wdata  out  8  received byte, LSB first on the line.
- frame_err  out  1  one-cycle pulse: stop bit sampled low.
- parity_err  out  1  one-cycle pulse: parity mismatch.
- overrun_err  out  1  one-cycle pulse: good frame dropped because fifo_full.

Behaviour:
- Reset (rst=1 at posedge clk):
  - State = IDLE; all counters = 0.
  - wr, frame_err, parity_err, overrun_err = 0; wdata = 0x00.
  - Applies mid-frame; the partial frame is discarded with no pulses.
- Tick generator:
  - Down-counter reloads clk_div when it reaches 0; tick is asserted while the counter is 0.
  - clk_div = 0 gives a tick every cycle.
  - Counter is held at 0 while en=0.
- en=0: next cycle state = IDLE, sample and bit counters cleared, no strobes. A frame in progress is lost silently.
- All state, counters and strobes advance only on tick, except the output strobes, which clear on the next clk.
- FSM:
  - IDLE: on a tick with rx=0 → START, sample counter s=0.
  - START: s increments per tick. At s = OVERSAMPLE/2-1 (mid-start):
    - rx=1 → IDLE (false start, no pulse).
    - rx=0 → DATA, s=0, bit counter b=0.
  - DATA: at s = OVERSAMPLE-1, shift rx into shreg[b] (LSB first), s=0.
    - After b=7: → PARITY if parity_en, else → STOP.
  - PARITY: at s = OVERSAMPLE-1, capture rx; perr = (^data ^ rx ^ parity_odd) != 0; → STOP.
  - STOP: at s = OVERSAMPLE-1 (mid-stop), evaluate, then → IDLE in the same tick, so a start bit right after the stop mid-point is detected.
- STOP evaluation priority (exactly one outcome per frame):
  1. rx=0 → frame_err, no write.
  2. Else perr → parity_err, no write.
  3. Else fifo_full → overrun_err, no write.
  4. Else wr=1 and wdata=byte.
- Timing:
  - Outputs are registered; the pulse appears the clk cycle after the mid-stop tick and lasts exactly 1 clk.
  - wdata holds the last written byte until the next write.
- parity_en and parity_odd are sampled at mid-start and held for the frame.
- Latency from start falling edge to wr: (OVERSAMPLE/2 + OVERSAMPLE*(9 + parity_en)) ticks + 1 clk, to within ±1 tick.

Decomposition:
- Package aucohl_uart_pkg holds:
  - FSM state localparams (IDLE, START, DATA, PARITY, STOP; 3-bit).
  - Default OVERSAMPLE = 16.
  - Frame data width = 8.
- One sub-module: aucohl_baud_tick (clk, rst, en, clk_div → tick), with synchronous active-high reset and the same tick semantics as aucohl_ticker.

Test Plan:
- Good byte: clk_div=0, parity off, send 0xA5 with 16 clk/bit → one wr pulse, wdata=0xA5, no error pulses, wr about 152 clk after the start edge.
- Parity: parity_en=1, parity_odd=0, send 0x07 with parity=1 → wr, wdata=0x07. Resend with parity=0 → parity_err pulse, no wr.
- Framing: send 0x3C with the stop bit held low → frame_err pulse, no wr. The receiver then re-syncs and the next frame 0x55 is written.
- Overrun: fifo_full=1 during a good 0x81 frame → overrun_err pulse, no wr. With fifo_full=0, the next frame 0x81 is written.
- False start: rx low for 4 ticks then high, clk_div=3 → returns to IDLE, no pulses. A following valid 0x12 is written.
- Abort: assert rst (or drop en) at DATA bit 4 of 0xFF → no pulses, state IDLE. A subsequent 0x00 frame is written correctly; back-to-back frames 0x11, 0x22 produce two writes.
